// File: rtl/udp_pkt_arbiter_pkg.sv
// Shared types and constants for the UDP TX packet arbiter.
package udp_pkt_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_XFER,
    ST_GAP
  } state_e;

  localparam int DEF_NUM_SRC  = 4;
  localparam int DEF_PKT_LEN  = 1283;
  localparam int DEF_FIFO_AW  = 12;
  localparam int DEF_GAP_CYC  = 16;
  localparam int DEF_WDOG_CYC = 1024;
  localparam int CNT_W        = 11;

  // Bits needed to hold 0..val-1, never less than one.
  function automatic int clog2(input int val);
    int r;
    r = 1;
    while ((1 << r) < val) r++;
    return r;
  endfunction

endpackage

// File: rtl/udp_pkt_arbiter_if.sv
// Source/FIFO side bundle of the UDP TX arbiter; master = arbiter, slave = sources + FIFO.
interface udp_pkt_arbiter_if
  import udp_pkt_arbiter_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int FIFO_AW = DEF_FIFO_AW
) ();

  logic [NUM_SRC-1:0]   src_req;
  logic [NUM_SRC-1:0]   src_grant;
  logic [NUM_SRC-1:0]   src_wr_en;
  logic [8*NUM_SRC-1:0] src_wr_data;
  logic [FIFO_AW:0]     fifo_usedw;
  logic                 fifo_wr_en;
  logic [7:0]           fifo_wr_data;
  logic                 pkt_done;
  logic [2:0]           pkt_src;
  logic                 err_trunc;
  logic                 err_wdog;

  modport master (
    input  src_req, src_wr_en, src_wr_data, fifo_usedw,
    output src_grant, fifo_wr_en, fifo_wr_data, pkt_done, pkt_src, err_trunc, err_wdog
  );

  modport slave (
    output src_req, src_wr_en, src_wr_data, fifo_usedw,
    input  src_grant, fifo_wr_en, fifo_wr_data, pkt_done, pkt_src, err_trunc, err_wdog
  );

endinterface

// File: rtl/udp_pkt_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module udp_pkt_arbiter_rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_SRC-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = 0;
    for (int off = NUM_SRC - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      if (req[cand]) begin
        onehot       = '0;
        onehot[cand] = 1'b1;
        idx          = IDX_W'(cand);
        any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/udp_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding the shared UDP TX write FIFO.
// Optional watchdog revoke enabled by defining UDP_ARB_WDOG_EN.
module udp_pkt_arbiter
  import udp_pkt_arbiter_pkg::*;
#(
  parameter int NUM_SRC  = DEF_NUM_SRC,
  parameter int PKT_LEN  = DEF_PKT_LEN,
  parameter int FIFO_AW  = DEF_FIFO_AW,
  parameter int GAP_CYC  = DEF_GAP_CYC,
  parameter int WDOG_CYC = DEF_WDOG_CYC
) (
  input logic                clk,
  input logic                rst_n,
  udp_pkt_arbiter_if.master  bus
);

  // state    | meaning
  // ST_IDLE  | wait for a requester and room for a whole packet
  // ST_GRANT | grant registered to the selected source
  // ST_XFER  | forward granted bytes until PKT_LEN, truncation or watchdog
  // ST_GAP   | enforced idle gap; rr pointer already advanced

  localparam int SEL_W = clog2(NUM_SRC);
  localparam int GAP_W = clog2(GAP_CYC + 1);
  localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(PKT_LEN - 1);
  localparam logic [GAP_W-1:0]   GAP_LOAD = GAP_W'(GAP_CYC - 1);
  localparam logic [FIFO_AW:0]   DEPTH    = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   NEED     = (FIFO_AW + 1)'(PKT_LEN);

  if (GAP_CYC < 1 || WDOG_CYC < 1 || PKT_LEN > (1 << CNT_W)) begin : g_cfg_check
    $error("udp_pkt_arbiter: unsupported parameter combination");
  end

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d, rr_ptr_q, rr_ptr_d, sel_next;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic                 wr_en_q, wr_en_d;
  logic [7:0]           wr_data_q, wr_data_d;
  logic                 done_pend_q, done_pend_d;
  logic                 pkt_done_q, pkt_done_d;
  logic [2:0]           pkt_src_q, pkt_src_d;
  logic                 err_trunc_q, err_trunc_d;
  logic [NUM_SRC-1:0]   pick_oh;
  logic [SEL_W-1:0]     pick_idx;
  logic                 pick_any;
  logic [FIFO_AW:0]     fifo_free;
  logic                 room, sel_req, sel_wr;
  logic [7:0]           sel_byte;

`ifdef UDP_ARB_WDOG_EN
  localparam int WD_W = clog2(WDOG_CYC);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WDOG_CYC - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_wdog_q, err_wdog_d;
  assign bus.err_wdog = err_wdog_q;
`else
  assign bus.err_wdog = 1'b0;
`endif

  udp_pkt_arbiter_rr_pick #(.NUM_SRC(NUM_SRC), .IDX_W(SEL_W)) u_pick (
    .req    (bus.src_req),
    .ptr    (rr_ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign fifo_free = DEPTH - bus.fifo_usedw;
  assign room      = fifo_free >= NEED;
  assign sel_req   = bus.src_req[sel_q];
  assign sel_wr    = bus.src_wr_en[sel_q];
  assign sel_byte  = bus.src_wr_data[{sel_q, 3'b000} +: 8];
  assign sel_next  = (sel_q == SEL_W'(NUM_SRC - 1)) ? '0 : sel_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    grant_d     = grant_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    done_pend_d = 1'b0;
    pkt_done_d  = done_pend_q;
    pkt_src_d   = done_pend_q ? 3'(sel_q) : pkt_src_q;
    err_trunc_d = err_trunc_q;
`ifdef UDP_ARB_WDOG_EN
    wd_d        = wd_q;
    err_wdog_d  = err_wdog_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any && room) begin
          sel_d   = pick_idx;
          grant_d = pick_oh;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        state_d = ST_XFER;
`ifdef UDP_ARB_WDOG_EN
        wd_d    = WD_LOAD;
`endif
      end
      ST_XFER: begin
        // A final byte wins over a simultaneous req drop: that packet is complete.
        if (sel_wr && cnt_q >= LAST_IDX) begin
          wr_en_d     = 1'b1;
          wr_data_d   = sel_byte;
          done_pend_d = 1'b1;
          grant_d     = '0;
          gap_d       = GAP_LOAD;
          rr_ptr_d    = sel_next;
          state_d     = ST_GAP;
        end else if (!sel_req) begin
          err_trunc_d = 1'b1;
          grant_d     = '0;
          gap_d       = GAP_LOAD;
          rr_ptr_d    = sel_next;
          state_d     = ST_GAP;
        end else if (sel_wr) begin
          wr_en_d     = 1'b1;
          wr_data_d   = sel_byte;
          cnt_d       = cnt_q + 1'b1;
`ifdef UDP_ARB_WDOG_EN
          wd_d        = WD_LOAD;
        end else if (wd_q == '0) begin
          err_wdog_d  = 1'b1;
          grant_d     = '0;
          gap_d       = GAP_LOAD;
          rr_ptr_d    = sel_next;
          state_d     = ST_GAP;
        end else begin
          wd_d        = wd_q - 1'b1;
`endif
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      grant_q     <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      done_pend_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_src_q   <= '0;
      err_trunc_q <= 1'b0;
`ifdef UDP_ARB_WDOG_EN
      wd_q        <= '0;
      err_wdog_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      grant_q     <= grant_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      done_pend_q <= done_pend_d;
      pkt_done_q  <= pkt_done_d;
      pkt_src_q   <= pkt_src_d;
      err_trunc_q <= err_trunc_d;
`ifdef UDP_ARB_WDOG_EN
      wd_q        <= wd_d;
      err_wdog_q  <= err_wdog_d;
`endif
    end
  end

  assign bus.src_grant    = grant_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_wr_data = wr_data_q;
  assign bus.pkt_done     = pkt_done_q;
  assign bus.pkt_src      = pkt_src_q;
  assign bus.err_trunc    = err_trunc_q;

endmodule
